multicycle_main_control: RTL

Multi-cycle main control FSM for the RV32I-subset datapath. It decodes the instruction opcode and sequences fetch, decode, execute, memory and write-back. Each cycle it drives the 2-bit ALU operation class consumed by the ALU control decoder (00 = add, 01 = subtract, 10 = use funct field), plus all datapath strobes. It also stalls on a memory-ready handshake, traps illegal opcodes and counts retired instructions.

---
 rtl/multicycle_main_control.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/multicycle_main_control.sv
// Multi-cycle main control FSM for the RV32I-subset datapath: sequences
// fetch/decode/execute/memory/write-back, stalls on mem_ready, traps bad opcodes.
module multicycle_main_control (
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic [1:0]  alu_op,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic        mem_read,
   output logic        mem_write,
   output logic        i_or_d,
   output logic        ir_write,
   output logic        pc_en,
   output logic        pc_src,
   output logic        reg_write,
   output logic        mem_to_reg,
   output logic        illegal,
   output logic [15:0] retired
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [3:0] {
      IDLE, FETCH, DECODE, EXEC_R, EXEC_I, ADDR,
      MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, TRAP
   } state_t;

   // Registered Moore strobes; fetch/branch/wb are qualifiers for the gated enables.
   typedef struct packed {
      logic [1:0] alu_op;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       mem_read;
      logic       mem_write;
      logic       i_or_d;
      logic       pc_src;
      logic       mem_to_reg;
      logic       illegal;
      logic       fetch;
      logic       branch;
      logic       wb;
   } ctl_t;

   state_t      state, next_state;
   ctl_t        ctl_q;
   logic [15:0] retired_q;
   logic        retire_evt;

   function automatic ctl_t decode_ctl(input state_t s);
      ctl_t c;
      c = '0;
      case (s)
         FETCH: begin
            c.mem_read  = 1'b1;
            c.alu_src_b = 2'b01;
            c.fetch     = 1'b1;
         end
         DECODE: c.alu_src_b = 2'b10;
         EXEC_R: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = 2'b10;
         end
         EXEC_I, ADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         MEM_RD: begin
            c.mem_read = 1'b1;
            c.i_or_d   = 1'b1;
         end
         MEM_WR: begin
            c.mem_write = 1'b1;
            c.i_or_d    = 1'b1;
         end
         WB_ALU: c.wb = 1'b1;
         WB_MEM: begin
            c.wb         = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         BRANCH: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = 2'b01;
            c.pc_src    = 1'b1;
            c.branch    = 1'b1;
         end
         TRAP:    c.illegal = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

   always_comb begin
      next_state = state;
      case (state)
         IDLE:   next_state = FETCH;
         FETCH:  if (mem_ready) next_state = DECODE;
         DECODE: begin
            case (opcode)
               OP_R:               next_state = EXEC_R;
               OP_I:               next_state = EXEC_I;
               OP_LOAD, OP_STORE:  next_state = ADDR;
               OP_BRANCH:          next_state = BRANCH;
               default:            next_state = TRAP;
            endcase
         end
         EXEC_R, EXEC_I: next_state = WB_ALU;
         // Opcode is still held in the IR, so load/store is re-resolved here.
         ADDR:   next_state = (opcode == OP_STORE) ? MEM_WR : MEM_RD;
         MEM_RD: if (mem_ready) next_state = WB_MEM;
         MEM_WR: if (mem_ready) next_state = FETCH;
         WB_ALU, WB_MEM, BRANCH: next_state = FETCH;
         TRAP:    next_state = TRAP;
         default: next_state = IDLE;
      endcase
   end

   assign retire_evt = (next_state == FETCH) &&
                       (state inside {MEM_WR, WB_ALU, WB_MEM, BRANCH});

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         ctl_q     <= '0;
         retired_q <= '0;
      end else begin
         state <= next_state;
         ctl_q <= decode_ctl(next_state);
         if (retire_evt) retired_q <= retired_q + 16'd1;
      end
   end

   assign alu_op     = ctl_q.alu_op;
   assign alu_src_a  = ctl_q.alu_src_a;
   assign alu_src_b  = ctl_q.alu_src_b;
   assign mem_read   = ctl_q.mem_read;
   assign mem_write  = ctl_q.mem_write;
   assign i_or_d     = ctl_q.i_or_d;
   assign pc_src     = ctl_q.pc_src;
   assign mem_to_reg = ctl_q.mem_to_reg;
   assign illegal    = ctl_q.illegal;
   // Enables react to mem_ready/zero within the same cycle.
   assign ir_write   = ctl_q.fetch & mem_ready;
   assign pc_en      = (ctl_q.fetch & mem_ready) | (ctl_q.branch & zero);
   assign reg_write  = ctl_q.wb;
   assign retired    = retired_q;

endmodule
